core_scheduler: RTL and testbench

Per-core instruction sequencer for miniGPU. It steps the shared `core_state` bus through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE so the fetcher, decoder, per-thread LSUs and the ALUs each act in their own state; the ALUs compute in EXECUTE (3'b101). It holds the core's single program counter, detects end-of-kernel (RET), and flags thread PC divergence. It sits in each core between the dispatcher and the per-thread datapath.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/core_scheduler_if.sv | 28 ++
 rtl/core_scheduler.sv | 112 +++++++++++
 tb/tb_core_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared miniGPU constants: core_state encodings seen by the fetcher, decoder, LSUs and ALUs.
// Pure definitions, no logic.
package gpu_pkg;

    localparam int PC_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

endpackage

// File: rtl/core_scheduler_if.sv
// Scheduler bus: dispatcher/datapath side is the master, the scheduler the slave.
// Plain level signals; stalls are expressed through instr_valid and lsu_busy.
interface core_scheduler_if #(
    parameter int THREADS = 4,
    parameter int PC_W    = 8
);
    logic                    start;
    logic [THREADS-1:0]      thread_mask;
    logic                    instr_valid;
    logic                    decoded_ret;
    logic [THREADS-1:0]      lsu_busy;
    logic [THREADS*PC_W-1:0] next_pc;
    logic [2:0]              core_state;
    logic [PC_W-1:0]         current_pc;
    logic                    fetch_req;
    logic                    done;
    logic                    diverged;

    modport master (
        output start, thread_mask, instr_valid, decoded_ret, lsu_busy, next_pc,
        input  core_state, current_pc, fetch_req, done, diverged
    );

    modport slave (
        input  start, thread_mask, instr_valid, decoded_ret, lsu_busy, next_pc,
        output core_state, current_pc, fetch_req, done, diverged
    );
endinterface

// File: rtl/core_scheduler.sv
// Per-core sequencer: FETCH..UPDATE loop, single PC, RET detect, sticky divergence flag.
// 6 cycles per instruction plus fetch stalls (instr_valid low) and WAIT stalls (active lsu_busy).
module core_scheduler #(
    parameter int THREADS = 4,
    parameter int PC_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    core_scheduler_if.slave  bus
);
    import gpu_pkg::*;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    current_pc_q, current_pc_d;
    logic               diverged_q, diverged_d;
    logic [THREADS-1:0] active_mask_q, active_mask_d;

    logic [PC_W-1:0]    sel_pc;
    logic               pc_differs;

    // Lowest-indexed active thread supplies the PC; any other active thread disagreeing is divergence.
    always_comb begin
        sel_pc     = '0;
        pc_differs = 1'b0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (active_mask_q[i]) begin
                sel_pc = bus.next_pc[i*PC_W +: PC_W];
            end
        end
        for (int i = 0; i < THREADS; i++) begin
            if (active_mask_q[i] && (bus.next_pc[i*PC_W +: PC_W] != sel_pc)) begin
                pc_differs = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        current_pc_d  = current_pc_q;
        diverged_d    = diverged_q;
        active_mask_d = active_mask_q;

        unique case (state_q)
            S_IDLE: begin
                current_pc_d = '0;
                diverged_d   = 1'b0;
                if (bus.start) begin
                    if (bus.thread_mask != '0) begin
                        active_mask_d = bus.thread_mask;
                        state_d       = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (bus.instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT: begin
                if ((bus.lsu_busy & active_mask_q) == '0) begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                if (pc_differs) begin
                    diverged_d = 1'b1;
                end
                if (bus.decoded_ret) begin
                    state_d = S_DONE;
                end else begin
                    current_pc_d = sel_pc;
                    state_d      = S_FETCH;
                end
            end
            S_DONE: begin
                // Clear on the way out so IDLE already shows PC 0 and no divergence.
                if (!bus.start) begin
                    current_pc_d = '0;
                    diverged_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            current_pc_q  <= '0;
            diverged_q    <= 1'b0;
            active_mask_q <= '0;
        end else begin
            state_q       <= state_d;
            current_pc_q  <= current_pc_d;
            diverged_q    <= diverged_d;
            active_mask_q <= active_mask_d;
        end
    end

    assign bus.core_state = state_q;
    assign bus.current_pc = current_pc_q;
    assign bus.fetch_req  = (state_q == S_FETCH);
    assign bus.done       = (state_q == S_DONE);
    assign bus.diverged   = diverged_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: directed scenarios plus random kernels checked against
// an instruction-level model (expected state sequence per instruction, PC and divergence rules).
module tb_core_scheduler;
    localparam int THREADS = 4;
    localparam int PC_W    = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_REQUEST = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_EXECUTE = 3'd5;
    localparam logic [2:0] ST_UPDATE  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    core_scheduler_if #(.THREADS(THREADS), .PC_W(PC_W)) bus();

    core_scheduler #(.THREADS(THREADS), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model state
    logic [PC_W-1:0]    m_pc   = '0;
    logic               m_div  = 1'b0;
    logic [THREADS-1:0] m_mask = '0;
    logic [PC_W-1:0]    pcs [THREADS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic [2:0] es, input string where);
        check({where, "/state"},    32'(bus.core_state), 32'(es));
        check({where, "/fetch_req"}, 32'(bus.fetch_req), 32'(es == ST_FETCH));
        check({where, "/done"},     32'(bus.done),       32'(es == ST_DONE));
        check({where, "/pc"},       32'(bus.current_pc), 32'(m_pc));
        check({where, "/diverged"}, 32'(bus.diverged),   32'(m_div));
    endtask

    // Called at a falling edge with this cycle's inputs applied.
    task automatic step(input logic [2:0] es, input string where);
        check_outputs(es, where);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [THREADS*PC_W-1:0] pack_pcs();
        logic [THREADS*PC_W-1:0] r;
        r = '0;
        for (int i = 0; i < THREADS; i++) r[i*PC_W +: PC_W] = pcs[i];
        return r;
    endfunction

    // Randomise everything the scheduler should ignore in the current state.
    task automatic noise();
        bus.instr_valid = 1'($urandom);
        bus.decoded_ret = 1'($urandom);
        bus.lsu_busy    = THREADS'($urandom);
        bus.next_pc     = (THREADS*PC_W)'($urandom);
        bus.thread_mask = THREADS'($urandom);
    endtask

    // Model of UPDATE: PC from the lowest active thread, divergence if active PCs disagree.
    task automatic model_update(input logic ret);
        logic [PC_W-1:0] act_q[$];
        for (int i = 0; i < THREADS; i++) if (m_mask[i]) act_q.push_back(pcs[i]);
        foreach (act_q[k]) if (act_q[k] != act_q[0]) m_div = 1'b1;
        if (!ret) m_pc = act_q[0];
    endtask

    task automatic launch(input logic [THREADS-1:0] mask);
        noise();
        bus.start       = 1'b1;
        bus.thread_mask = mask;
        step(ST_IDLE, "launch");
        if (mask != '0) m_mask = mask;
    endtask

    task automatic run_instr(input int f_delay, input int busy_cycles,
                             input logic [THREADS-1:0] busy_vec, input logic ret);
        int n_wait;
        for (int k = 0; k <= f_delay; k++) begin
            noise();
            bus.instr_valid = (k == f_delay);
            step(ST_FETCH, "fetch");
        end
        noise(); step(ST_DECODE, "decode");
        noise(); step(ST_REQUEST, "request");
        n_wait = ((busy_vec & m_mask) != '0) ? busy_cycles + 1 : 1;
        for (int w = 0; w < n_wait; w++) begin
            noise();
            bus.lsu_busy = (w < busy_cycles) ? busy_vec : (bus.lsu_busy & ~m_mask);
            step(ST_WAIT, "wait");
        end
        noise(); step(ST_EXECUTE, "execute");
        noise();
        bus.decoded_ret = ret;
        bus.next_pc     = pack_pcs();
        step(ST_UPDATE, "update");
        model_update(ret);
    endtask

    task automatic finish_kernel(input int hold);
        for (int h = 0; h < hold; h++) begin
            noise(); bus.start = 1'b1; step(ST_DONE, "done_hold");
        end
        noise(); bus.start = 1'b0; step(ST_DONE, "done_exit");
        m_pc  = '0;
        m_div = 1'b0;
        noise(); bus.start = 1'b0; step(ST_IDLE, "idle");
    endtask

    task automatic set_all_pcs(input logic [PC_W-1:0] v);
        for (int i = 0; i < THREADS; i++) pcs[i] = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.thread_mask = '0; bus.instr_valid = 1'b0;
        bus.decoded_ret = 1'b0; bus.lsu_busy = '0; bus.next_pc = '0;
        set_all_pcs('0);

        #1 reset = 1'b0;
        #1 check_outputs(ST_IDLE, "reset");
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        step(ST_IDLE, "idle0");

        // Single instruction, memory stall, fetch stall, RET at PC 7
        launch(4'b1111);
        set_all_pcs(8'd1);
        run_instr(0, 0, '0, 1'b0);
        set_all_pcs(8'd7);
        run_instr(10, 5, 4'b0100, 1'b0);
        run_instr(0, 0, '0, 1'b1);
        finish_kernel(3);

        // Busy bit of an inactive thread must not stall WAIT
        launch(4'b1011);
        set_all_pcs(8'd3);
        run_instr(0, 5, 4'b0100, 1'b0);
        run_instr(0, 0, '0, 1'b1);
        finish_kernel(1);

        // Divergence: sticky until IDLE; PC 255 taken as is
        launch(4'b0110);
        pcs[0] = 8'h55; pcs[1] = 8'd9; pcs[2] = 8'd12; pcs[3] = 8'hAA;
        run_instr(1, 0, '0, 1'b0);
        set_all_pcs(8'd255);
        run_instr(0, 2, 4'b0010, 1'b0);
        run_instr(0, 0, '0, 1'b1);
        finish_kernel(0);

        // Random kernels
        for (int kn = 0; kn < 30; kn++) begin
            logic [THREADS-1:0] mask;
            int n;
            mask = (kn % 10 == 9) ? '0 : THREADS'($urandom_range(0, 15));
            launch(mask);
            if (mask != '0) begin
                n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_all_pcs(PC_W'($urandom_range(0, 255)));
                    end else begin
                        for (int i = 0; i < THREADS; i++) pcs[i] = PC_W'($urandom_range(0, 255));
                    end
                    run_instr($urandom_range(0, 3), $urandom_range(0, 4),
                              THREADS'($urandom_range(0, 15)), (j == n - 1));
                end
            end
            finish_kernel($urandom_range(0, 2));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                noise(); bus.start = 1'b0; step(ST_IDLE, "gap");
            end
        end

        // Asynchronous reset in the middle of WAIT
        launch(4'b1111);
        set_all_pcs(8'd2);
        run_instr(0, 0, '0, 1'b0);
        noise(); bus.instr_valid = 1'b1; step(ST_FETCH, "rst_fetch");
        noise(); step(ST_DECODE, "rst_decode");
        noise(); step(ST_REQUEST, "rst_request");
        noise(); bus.lsu_busy = 4'b1111; step(ST_WAIT, "rst_wait");
        #2 reset = 1'b0;
        m_pc  = '0;
        m_div = 1'b0;
        #1 check_outputs(ST_IDLE, "async_reset");
        @(negedge clk);
        bus.start = 1'b1;
        check_outputs(ST_IDLE, "reset_held");
        reset = 1'b1;
        launch('0);
        finish_kernel(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
